// File: rtl/fir_datapath.sv
`default_nettype none
// ============================================================================
// Module   : fir_datapath
// Purpose  : FIR execution datapath - 16-entry register file with a
//            COPY/LOAD/ADD/SUB/MUL ALU and a same-cycle overflow flag.
// Revision : 1.0 - initial release
// ============================================================================
module fir_datapath #(
  parameter int DATA_W   = 16,
  parameter int NUM_REGS = 16
) (
  input  logic              clk,
  input  logic              n_reset,
  input  logic [2:0]        op,
  input  logic [3:0]        src1,
  input  logic [3:0]        src2,
  input  logic [3:0]        dest,
  input  logic [DATA_W-1:0] ext_sample,
  input  logic [DATA_W-1:0] ext_coeff,
  output logic              overflow,
  output logic [DATA_W-1:0] outreg_data
);

  localparam logic [2:0] c_op_copy  = 3'b001;
  localparam logic [2:0] c_op_lds   = 3'b010;
  localparam logic [2:0] c_op_ldc   = 3'b011;
  localparam logic [2:0] c_op_add   = 3'b100;
  localparam logic [2:0] c_op_sub   = 3'b101;
  localparam logic [2:0] c_op_mul   = 3'b110;

  logic [DATA_W-1:0]   r_regs [NUM_REGS];
  logic [DATA_W-1:0]   w_a;
  logic [DATA_W-1:0]   w_b;
  logic [DATA_W:0]     w_sum;
  logic [DATA_W:0]     w_diff;
  logic [2*DATA_W-1:0] w_prod;
  logic [DATA_W-1:0]   w_result;
  logic                w_we;
  logic                w_ovf;

  // Operands always come from the pre-edge register values (no bypass).
  assign w_a = r_regs[src1];
  assign w_b = r_regs[src2];

  // One extra bit on add/sub exposes carry and borrow directly.
  assign w_sum  = {1'b0, w_a} + {1'b0, w_b};
  assign w_diff = {1'b0, w_a} - {1'b0, w_b};
  assign w_prod = {{DATA_W{1'b0}}, w_a} * {{DATA_W{1'b0}}, w_b};

  always_comb begin
    w_we     = 1'b0;
    w_ovf    = 1'b0;
    w_result = '0;
    case (op)
      c_op_copy: begin
        w_we     = 1'b1;
        w_result = w_a;
      end
      c_op_lds: begin
        w_we     = 1'b1;
        w_result = ext_sample;
      end
      c_op_ldc: begin
        w_we     = 1'b1;
        w_result = ext_coeff;
      end
      c_op_add: begin
        w_we     = 1'b1;
        w_result = w_sum[DATA_W-1:0];
        w_ovf    = w_sum[DATA_W];
      end
      c_op_sub: begin
        w_we     = 1'b1;
        w_result = w_diff[DATA_W-1:0];
        w_ovf    = w_diff[DATA_W];
      end
      c_op_mul: begin
        w_we     = 1'b1;
        w_result = w_prod[DATA_W-1:0];
        w_ovf    = |w_prod[2*DATA_W-1:DATA_W];
      end
      default: begin
        w_we     = 1'b0;
      end
    endcase
  end

  // Truncated result is stored even on overflow; the controller decides.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_we) begin
      r_regs[dest] <= w_result;
    end
  end

  assign overflow    = w_ovf;
  assign outreg_data = r_regs[0];

endmodule
`default_nettype wire

// File: tb/tb_fir_datapath.sv
`default_nettype none
// ============================================================================
// Module   : tb_fir_datapath
// Purpose  : Scoreboard bench for fir_datapath against an arithmetic model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fir_datapath;

  logic        clk = 1'b0;
  logic        n_reset;
  logic [2:0]  op;
  logic [3:0]  src1;
  logic [3:0]  src2;
  logic [3:0]  dest;
  logic [15:0] ext_sample;
  logic [15:0] ext_coeff;
  logic        overflow;
  logic [15:0] outreg_data;

  always #5 clk = ~clk;

  fir_datapath #(.DATA_W(16), .NUM_REGS(16)) dut (
    .clk         (clk),
    .n_reset     (n_reset),
    .op          (op),
    .src1        (src1),
    .src2        (src2),
    .dest        (dest),
    .ext_sample  (ext_sample),
    .ext_coeff   (ext_coeff),
    .overflow    (overflow),
    .outreg_data (outreg_data)
  );

  typedef struct {
    string name;
    bit    ovf;
    int    r0;
  } exp_t;

  exp_t sbq[$];
  int   model[16];
  int   tests = 0;
  int   fails = 0;

  task automatic clear_model();
    for (int i = 0; i < 16; i++) model[i] = 0;
  endtask

  task automatic push_exp(input string name, input bit ovf, input int r0);
    exp_t e;
    e.name = name;
    e.ovf  = ovf;
    e.r0   = r0;
    sbq.push_back(e);
  endtask

  // Drives one command and records what the cycle must show: overflow for
  // this op and r0 as left by earlier edges. The model then takes the write.
  task automatic issue(input string name, input int o, input int s1, input int s2,
                       input int d, input int samp, input int coeff);
    int     a, b, res;
    bit     ovf, wr;
    longint p;
    @(posedge clk);
    #1;
    op = 3'(o); src1 = 4'(s1); src2 = 4'(s2); dest = 4'(d);
    ext_sample = 16'(samp); ext_coeff = 16'(coeff);
    a = model[s1]; b = model[s2];
    wr = 1'b1; ovf = 1'b0; res = 0;
    case (o)
      1: res = a;
      2: res = samp & 65535;
      3: res = coeff & 65535;
      4: begin res = a + b; ovf = (res > 65535); res = res % 65536; end
      5: begin ovf = (b > a); res = (a - b + 65536) % 65536; end
      6: begin p = longint'(a) * longint'(b); ovf = (p > 65535); res = int'(p % 65536); end
      default: wr = 1'b0;
    endcase
    if (!n_reset) wr = 1'b0;
    push_exp(name, ovf, model[0]);
    if (wr) model[d] = res;
  endtask

  task automatic load(input string name, input int r, input int v);
    if (r % 2 == 0) issue(name, 2, 0, 0, r, v, 16'hDEAD);
    else            issue(name, 3, 0, 0, r, 16'hBEEF, v);
  endtask

  // COPY r -> r0 so the following cycle's check shows register r.
  task automatic peek(input string name, input int r);
    issue(name, 1, r, 0, 0, 0, 0);
  endtask

  task automatic nop(input string name);
    issue(name, 0, 0, 0, 0, 0, 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (sbq.size() > 0) begin
      e = sbq.pop_front();
      tests++;
      if (overflow !== e.ovf || outreg_data !== 16'(e.r0)) begin
        fails++;
        $display("FAIL %s: got overflow=%0b outreg_data=%h, required overflow=%0b outreg_data=%h",
                 e.name, overflow, outreg_data, e.ovf, 16'(e.r0));
      end
    end
  end

  initial begin
    int budget;
    n_reset = 1'b0;
    op = 3'd0; src1 = 4'd0; src2 = 4'd0; dest = 4'd0;
    ext_sample = 16'd0; ext_coeff = 16'd0;
    clear_model();

    for (int i = 0; i < 6; i++)
      issue("reset_traffic", int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
            int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
            int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)));
    @(posedge clk);
    #1;
    op = 3'd0;
    n_reset = 1'b1;

    for (int r = 1; r < 16; r++) peek("reset_regs_zero", r);
    nop("reset_regs_zero");

    issue("load_coeff", 3, 0, 0, 1, 0, 16'h0123);
    peek("copy_r1", 1);
    nop("copy_r1_result");

    load("add_setup", 0, 16'hFFFF);
    load("add_setup", 11, 16'h0002);
    issue("add_carry", 4, 0, 11, 0, 0, 0);
    nop("add_carry_result");
    load("add_setup2", 0, 16'h1000);
    issue("add_no_carry", 4, 0, 11, 0, 0, 0);
    nop("add_no_carry_result");

    load("sub_setup", 0, 16'h0005);
    load("sub_setup", 10, 16'h0007);
    issue("sub_borrow", 5, 0, 10, 0, 0, 0);
    issue("sub_zero_acc", 5, 0, 0, 0, 0, 0);
    nop("sub_zero_result");

    load("mul_setup", 1, 16'h0100);
    load("mul_setup", 6, 16'h0080);
    issue("mul_fits", 6, 1, 6, 10, 0, 0);
    peek("mul_fits_r10", 10);
    nop("mul_fits_result");
    load("mul_setup2", 6, 16'h0100);
    issue("mul_overflow", 6, 1, 6, 10, 0, 0);
    peek("mul_overflow_r10", 10);
    nop("mul_overflow_result");

    for (int r = 5; r <= 9; r++) load("chain_setup", r, r);
    issue("chain_9_8", 1, 8, 0, 9, 0, 0);
    issue("chain_8_7", 1, 7, 0, 8, 0, 0);
    issue("chain_7_6", 1, 6, 0, 7, 0, 0);
    issue("chain_6_5", 1, 5, 0, 6, 0, 0);
    for (int r = 5; r <= 9; r++) peek("chain_read", r);
    load("self_add_setup", 3, 4);
    issue("self_add", 4, 3, 3, 3, 0, 0);
    peek("self_add_read", 3);
    nop("self_add_result");

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 5) == 0)
        peek("random_peek", int'($urandom_range(1, 15)));
      else
        issue("random_op", int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
              int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
              int'($urandom_range(0, 65535)), int'($urandom_range(0, 65535)));
    end

    // Reset pulse between edges while a MUL into r0 is pending.
    load("async_setup", 0, 16'h5555);
    load("async_setup", 1, 16'h1234);
    load("async_setup", 2, 16'h0010);
    @(posedge clk);
    #1;
    op = 3'b110; src1 = 4'd1; src2 = 4'd2; dest = 4'd0;
    #1;
    n_reset = 1'b0;
    clear_model();
    push_exp("async_reset_drop", 1'b0, 0);
    #2;
    n_reset = 1'b1;
    peek("async_no_write_r1", 1);
    peek("async_no_write_r2", 2);
    nop("async_after");
    nop("drain");

    budget = 0;
    while (sbq.size() > 0 && budget < 20) begin
      @(posedge clk);
      budget++;
    end
    if (sbq.size() > 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: got %0d pending checks, required 0", sbq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/fir_datapath.md
# fir_datapath

Execution datapath of the FIR filter. It accepts one register-transfer command per clock from the filter controller: a 3-bit op plus src1/src2/dest register indices. It executes the command against a 16-entry register file and returns a combinational `overflow` flag that the controller samples in the same cycle. Register 0 is the accumulator and drives the filter output.

## Interface
Parameters:
- `DATA_W`, 16, width of every register, external load operand and ALU result.
- `NUM_REGS`, 16, register-file depth; indices are 4 bits, so the value is fixed at 16.

Ports:
- `clk`  input  1  clock; all register writes on the rising edge.
- `n_reset`  input  1  asynchronous, active-low reset.
- `op`  input  3  command: 000 NOP, 001 COPY, 010 LOAD_SAMPLE, 011 LOAD_COEFF, 100 ADD, 101 SUB, 110 MUL, 111 NOP.
- `src1`  input  4  first operand register index.
- `src2`  input  4  second operand register index.
- `dest`  input  4  destination register index.
- `ext_sample`  input  DATA_W  sample operand for LOAD_SAMPLE.
- `ext_coeff`  input  DATA_W  coefficient operand for LOAD_COEFF.
- `overflow`  output  1  combinational; set when the ALU result of the current op does not fit in DATA_W bits.
- `outreg_data`  output  DATA_W  current contents of register 0 (registered value).

## Operation
- Register file `r[0..15]`, unsigned DATA_W bits.
- All reads are combinational from the current register values. A write to `dest` takes effect at the next rising edge.
- Op semantics (result R is written to `r[dest]` at the edge):
  - NOP (000, 111): no write; `overflow`=0.
  - COPY: R = `r[src1]`; `overflow`=0.
  - LOAD_SAMPLE: R = `ext_sample`; `overflow`=0.
  - LOAD_COEFF: R = `ext_coeff`; `overflow`=0.
  - ADD: R = low DATA_W bits of `r[src1]` + `r[src2]`; `overflow` = carry out of bit DATA_W-1.
  - SUB: R = low DATA_W bits of `r[src1]` - `r[src2]`; `overflow` = borrow, i.e. `r[src2]` > `r[src1]`.
  - MUL: full 2*DATA_W-bit unsigned product P; R = P[DATA_W-1:0]; `overflow` = 1 when P[2*DATA_W-1:DATA_W] is nonzero.
- The write happens even when `overflow`=1; the truncated result is stored. Discarding the result is the controller's decision.
- SUB with src1 = src2 = dest = 0 clears the accumulator (result 0, no overflow). The controller relies on this for accumulator zeroing.
- Any register, including r0, is a legal src or dest for any op.
- If dest equals src1 or src2, the operation reads the pre-edge value (no bypass). Example: ADD dest=0, src1=0 gives r0 ← r0_old + r[src2].
- `outreg_data` = r0 at all times.

## Timing
- Reset: all 16 registers are cleared to 0 asynchronously, so `outreg_data`=0. `overflow` then depends only on the inputs and the zeroed registers; with op=NOP it is 0.
- Reset asserted mid-command: the pending write is abandoned and all registers read 0 immediately. The first edge after deassertion executes whatever op is presented.
- Latency: one command per cycle, with no stalls and no internal state beyond the register file.
  - A result written at edge N is readable as an operand in cycle N+1.
  - `outreg_data` reflects an r0 write at edge N immediately after edge N.
- `overflow` is purely combinational from `op`, `src1`, `src2` and the current register values. It is valid in the same cycle the op is presented, settling before the next edge, because the controller branches on it in that cycle.
- Back-to-back writes to the same dest: the last one wins at each edge. No hazards exist beyond the no-bypass read rule.

## Test plan
- Reset and load:
  - Stimulus: assert `n_reset`=0 with random op traffic, then release.
  - Required response: all registers read 0 and `outreg_data`=0.
  - Then LOAD_COEFF dest=1 with `ext_coeff`=0x0123, followed by COPY src1=1 → dest=0.
  - Required response: `outreg_data`=0x0123 one cycle after the COPY edge.
- ADD overflow:
  - Stimulus: r0=0xFFFF, r11=0x0002, ADD dest=0 src1=0 src2=11.
  - Required response: `overflow`=1 in the same cycle and r0=0x0001 after the edge.
  - Stimulus: r0=0x1000 with the same command.
  - Required response: `overflow`=0 and r0=0x1002.
- SUB borrow and zeroing:
  - Stimulus: r0=0x0005, r10=0x0007, SUB dest=0 src1=0 src2=10.
  - Required response: `overflow`=1 and r0=0xFFFE.
  - Stimulus: SUB 0,0,0.
  - Required response: r0=0 and `overflow`=0.
- MUL:
  - Stimulus: r1=0x0100, r6=0x0080, MUL dest=10.
  - Required response: r10=0x8000 and `overflow`=0.
  - Stimulus: r6=0x0100 with the same command.
  - Required response: r10=0x0000 and `overflow`=1.
- Shift chain, no bypass:
  - Stimulus: r5..r9 = 5, 6, 7, 8, 9; issue COPY 9←8, 8←7, 7←6, 6←5 on consecutive cycles.
  - Required response: r9=8, r8=7, r7=6, r6=5, r5=5.
  - Stimulus: ADD dest=3 src1=3 src2=3 with r3=4.
  - Required response: r3=8.
- Async reset mid-sequence:
  - Stimulus: pull `n_reset` low between clock edges during a MUL.
  - Required response: `outreg_data` drops to 0 immediately and no write lands at the following edge.
